// File: rtl/ex_mem_pkg.sv
// Shared widths, stall-mode encoding and the EX/MEM bundle.
// The stall mode is decoded from flush and the two stall requests.
package ex_mem_pkg;

    localparam int REG_ADDR_WIDTH  = 5;
    localparam int REG_DATA_WIDTH  = 32;
    localparam int HILO_TEMP_WIDTH = 64;
    localparam int CNT_WIDTH       = 2;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'd0,
        MODE_BUBBLE = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_FLUSH  = 2'd3
    } stall_mode_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0]  w_reg_addr;
        logic [REG_DATA_WIDTH-1:0]  w_reg_data;
        logic                       w_reg_en;
        logic [31:0]                hi;
        logic [31:0]                lo;
        logic                       hilo_wen;
        logic [HILO_TEMP_WIDTH-1:0] hilo_temp;
        logic [CNT_WIDTH-1:0]       cnt;
        logic                       valid;
    } ex_mem_t;

    // stall_ex=0 with stall_mem=1 cannot occur legally; it falls into hold.
    function automatic stall_mode_e decode_mode(
        input logic flush,
        input logic stall_ex,
        input logic stall_mem
    );
        if (flush)
            return MODE_FLUSH;
        else if (stall_ex && !stall_mem)
            return MODE_BUBBLE;
        else if (stall_mem)
            return MODE_HOLD;
        else
            return MODE_LOAD;
    endfunction

endpackage

// File: rtl/ex_mem_perf.sv
// Bubble and hold event counters for the EX/MEM register.
// Cleared by reset only; both wrap silently.
module ex_mem_perf
    import ex_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  stall_mode_e mode,
    output logic [31:0] bubble_cnt,
    output logic [31:0] hold_cnt
);

    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (mode == MODE_BUBBLE)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (mode == MODE_HOLD)
            hold_cnt_d = hold_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/bubble/hold/load control.
// Define EX_MEM_PERF_EN to add the bubble_cnt/hold_cnt counters.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_w_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0]  ex_w_reg_data,
    input  logic                       ex_w_reg_en,
    input  logic [31:0]                ex_hi,
    input  logic [31:0]                ex_lo,
    input  logic                       ex_hilo_wen,
    input  logic [HILO_TEMP_WIDTH-1:0] ex_hilo_temp,
    input  logic [CNT_WIDTH-1:0]       ex_cnt,
    input  logic                       stall_ex,
    input  logic                       stall_mem,
    input  logic                       flush,
    output logic [REG_ADDR_WIDTH-1:0]  mem_w_reg_addr,
    output logic [REG_DATA_WIDTH-1:0]  mem_w_reg_data,
    output logic                       mem_w_reg_en,
    output logic [31:0]                mem_hi,
    output logic [31:0]                mem_lo,
    output logic                       mem_hilo_wen,
    output logic [HILO_TEMP_WIDTH-1:0] hilo_temp_out,
    output logic [CNT_WIDTH-1:0]       cnt_out,
    output logic                       mem_valid
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]                bubble_cnt,
    output logic [31:0]                hold_cnt
`endif
);

    stall_mode_e mode;
    ex_mem_t     st_q, st_d;

    assign mode = decode_mode(flush, stall_ex, stall_mem);

    always_comb begin
        st_d = st_q;
        unique case (mode)
            MODE_FLUSH: st_d = '0;
            // Bubble still carries the multi-cycle partial state forward.
            MODE_BUBBLE: begin
                st_d           = '0;
                st_d.hilo_temp = ex_hilo_temp;
                st_d.cnt       = ex_cnt;
            end
            MODE_HOLD: st_d = st_q;
            MODE_LOAD: begin
                st_d.w_reg_addr = ex_w_reg_addr;
                st_d.w_reg_data = ex_w_reg_data;
                st_d.w_reg_en   = ex_w_reg_en;
                st_d.hi         = ex_hi;
                st_d.lo         = ex_lo;
                st_d.hilo_wen   = ex_hilo_wen;
                st_d.hilo_temp  = '0;
                st_d.cnt        = '0;
                st_d.valid      = 1'b1;
            end
            default: st_d = st_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st_q <= '0;
        else
            st_q <= st_d;
    end

    assign mem_w_reg_addr = st_q.w_reg_addr;
    assign mem_w_reg_data = st_q.w_reg_data;
    assign mem_w_reg_en   = st_q.w_reg_en;
    assign mem_hi         = st_q.hi;
    assign mem_lo         = st_q.lo;
    assign mem_hilo_wen   = st_q.hilo_wen;
    assign hilo_temp_out  = st_q.hilo_temp;
    assign cnt_out        = st_q.cnt;
    assign mem_valid      = st_q.valid;

`ifdef EX_MEM_PERF_EN
    ex_mem_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt)
    );
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed plus random bench for ex_mem against a rule-level model.
// Define EX_MEM_PERF_EN to also check the event counters.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ex_w_reg_addr;
    logic [31:0] ex_w_reg_data;
    logic        ex_w_reg_en;
    logic [31:0] ex_hi, ex_lo;
    logic        ex_hilo_wen;
    logic [63:0] ex_hilo_temp;
    logic [1:0]  ex_cnt;
    logic        stall_ex, stall_mem, flush;
    logic [4:0]  mem_w_reg_addr;
    logic [31:0] mem_w_reg_data;
    logic        mem_w_reg_en;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_hilo_wen;
    logic [63:0] hilo_temp_out;
    logic [1:0]  cnt_out;
    logic        mem_valid;
`ifdef EX_MEM_PERF_EN
    logic [31:0] bubble_cnt, hold_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // reference state
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_en;
    logic [31:0] m_hi, m_lo;
    logic        m_wen;
    logic [63:0] m_temp;
    logic [1:0]  m_cnt;
    logic        m_valid;
    logic [31:0] m_bub, m_hold;

    ex_mem dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_w_reg_addr  (ex_w_reg_addr),
        .ex_w_reg_data  (ex_w_reg_data),
        .ex_w_reg_en    (ex_w_reg_en),
        .ex_hi          (ex_hi),
        .ex_lo          (ex_lo),
        .ex_hilo_wen    (ex_hilo_wen),
        .ex_hilo_temp   (ex_hilo_temp),
        .ex_cnt         (ex_cnt),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .flush          (flush),
        .mem_w_reg_addr (mem_w_reg_addr),
        .mem_w_reg_data (mem_w_reg_data),
        .mem_w_reg_en   (mem_w_reg_en),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_hilo_wen   (mem_hilo_wen),
        .hilo_temp_out  (hilo_temp_out),
        .cnt_out        (cnt_out),
        .mem_valid      (mem_valid)
`ifdef EX_MEM_PERF_EN
        ,
        .bubble_cnt     (bubble_cnt),
        .hold_cnt       (hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_pipe();
        m_addr  = '0;
        m_data  = '0;
        m_en    = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        m_wen   = 1'b0;
        m_temp  = '0;
        m_cnt   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_pipe();
        m_bub  = '0;
        m_hold = '0;
    endtask

    // One clock edge as the rules describe it, in priority order.
    task automatic model_edge();
        if (flush) begin
            model_clear_pipe();
        end else if (stall_ex && !stall_mem) begin
            model_clear_pipe();
            m_temp = ex_hilo_temp;
            m_cnt  = ex_cnt;
            m_bub  = m_bub + 1;
        end else if (stall_mem) begin
            m_hold = m_hold + 1;
        end else begin
            m_addr  = ex_w_reg_addr;
            m_data  = ex_w_reg_data;
            m_en    = ex_w_reg_en;
            m_hi    = ex_hi;
            m_lo    = ex_lo;
            m_wen   = ex_hilo_wen;
            m_temp  = '0;
            m_cnt   = '0;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  64'(mem_w_reg_addr), 64'(m_addr));
        chk({tag, ".data"},  64'(mem_w_reg_data), 64'(m_data));
        chk({tag, ".en"},    64'(mem_w_reg_en),   64'(m_en));
        chk({tag, ".hi"},    64'(mem_hi),         64'(m_hi));
        chk({tag, ".lo"},    64'(mem_lo),         64'(m_lo));
        chk({tag, ".wen"},   64'(mem_hilo_wen),   64'(m_wen));
        chk({tag, ".temp"},  hilo_temp_out,       m_temp);
        chk({tag, ".cnt"},   64'(cnt_out),        64'(m_cnt));
        chk({tag, ".valid"}, 64'(mem_valid),      64'(m_valid));
`ifdef EX_MEM_PERF_EN
        chk({tag, ".bub"},   64'(bubble_cnt),     64'(m_bub));
        chk({tag, ".hold"},  64'(hold_cnt),       64'(m_hold));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic ctl(input logic f, input logic se, input logic sm);
        flush     = f;
        stall_ex  = se;
        stall_mem = sm;
    endtask

    task automatic rand_ex();
        ex_w_reg_addr = 5'($urandom);
        ex_w_reg_data = $urandom;
        ex_w_reg_en   = 1'($urandom);
        ex_hi         = $urandom;
        ex_lo         = $urandom;
        ex_hilo_wen   = 1'($urandom);
        ex_hilo_temp  = {$urandom, $urandom};
        ex_cnt        = 2'($urandom);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
`ifdef EX_MEM_PERF_EN
        chk({tag, ".bub0"}, 64'(bubble_cnt), 64'd0);
`endif
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rand_ex();
        ctl(1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // load
        ex_w_reg_addr = 5'd3;
        ex_w_reg_data = 32'h1234_5678;
        ex_w_reg_en   = 1'b1;
        step("load");
        chk("load.addr3", 64'(mem_w_reg_addr), 64'd3);
        chk("load.data", 64'(mem_w_reg_data), 64'h1234_5678);
        chk("load.valid", 64'(mem_valid), 64'd1);

        // hi/lo write then clear wen
        ex_hi       = 32'hAAAA_0000;
        ex_hilo_wen = 1'b1;
        step("hilo1");
        chk("hilo1.hi", 64'(mem_hi), 64'hAAAA_0000);
        chk("hilo1.wen", 64'(mem_hilo_wen), 64'd1);
        ex_hilo_wen = 1'b0;
        step("hilo2");
        chk("hilo2.wen", 64'(mem_hilo_wen), 64'd0);

        // bubble carries multi-cycle state, next load clears it
        ctl(1'b0, 1'b1, 1'b0);
        ex_cnt       = 2'd1;
        ex_hilo_temp = 64'h1_0000_0002;
        step("bubble");
        chk("bubble.en", 64'(mem_w_reg_en), 64'd0);
        chk("bubble.valid", 64'(mem_valid), 64'd0);
        chk("bubble.cnt", 64'(cnt_out), 64'd1);
        chk("bubble.temp", hilo_temp_out, 64'h1_0000_0002);
        ctl(1'b0, 1'b0, 1'b0);
        step("reload");
        chk("reload.cnt", 64'(cnt_out), 64'd0);

        // async reset mid-cycle after a load
        async_reset("arst");

        // hold for three edges with changing EX data
        ex_w_reg_data = 32'h55;
        step("hload");
        ctl(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            step("hold");
        end
        chk("hold.data", 64'(mem_w_reg_data), 64'h55);
`ifdef EX_MEM_PERF_EN
        chk("hold.cnt3", 64'(hold_cnt), 64'd3);
`endif

        // illegal combination behaves as hold
        ctl(1'b0, 1'b0, 1'b1);
        rand_ex();
        step("illegal");
        chk("illegal.data", 64'(mem_w_reg_data), 64'h55);

        // flush wins over stalls, also aborts multi-cycle state
        ctl(1'b0, 1'b1, 1'b0);
        ex_cnt       = 2'd2;
        ex_hilo_temp = 64'hDEAD_BEEF_0000_0001;
        step("pre_flush");
        ctl(1'b1, 1'b1, 1'b1);
        step("flush");
        chk("flush.data", 64'(mem_w_reg_data), 64'd0);
        chk("flush.cnt", 64'(cnt_out), 64'd0);
        chk("flush.temp", hilo_temp_out, 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            ctl(($urandom_range(7) == 0), 1'($urandom), 1'($urandom));
            if ($urandom_range(63) == 0)
                async_reset("rnd_rst");
            else
                step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
- REQ-001: clk  input  1  pipeline clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  reset, asynchronous, active-low.
- REQ-003: ex_w_reg_addr  input  REG_ADDR_WIDTH (5)  GPR write address from EX.
- REQ-004: ex_w_reg_data  input  REG_DATA_WIDTH (32)  GPR write data from EX.
- REQ-005: ex_w_reg_en  input  1  GPR write enable from EX.
- REQ-006: ex_hi, ex_lo  input  32 each  HI/LO write data from EX.
- REQ-007: ex_hilo_wen  input  1  HI/LO write enable from EX.
- REQ-008: ex_hilo_temp  input  64  multi-cycle partial result from EX.
- REQ-009: ex_cnt  input  2  multi-cycle step count from EX.
- REQ-010: stall_ex, stall_mem  input  1 each  stall requests from the stall controller.
- REQ-011: flush  input  1  pipeline flush.
- REQ-012: mem_w_reg_addr, mem_w_reg_data, mem_w_reg_en  output  5/32/1  registered GPR write fields to MEM.
- REQ-013: mem_hi, mem_lo, mem_hilo_wen  output  32/32/1  registered HI/LO fields; these are also the MEM-stage forwarding inputs of EX.
- REQ-014: hilo_temp_out, cnt_out  output  64/2  registered multi-cycle state fed back to EX.
- REQ-015: mem_valid  output  1  high when MEM holds a real instruction rather than a bubble.

Function
- REQ-016: Priority per edge: flush, then bubble, then hold, then load.
- REQ-017: Flush: all outputs go to zero on the next edge, regardless of stall inputs.
- REQ-018: Bubble (stall_ex=1, stall_mem=0): all pipeline outputs go to zero and mem_valid=0.
- REQ-019: During a bubble, hilo_temp_out<=ex_hilo_temp and cnt_out<=ex_cnt.
- REQ-020: Hold (stall_ex=1, stall_mem=1): every output keeps its value, including hilo_temp_out and cnt_out.
- REQ-021: Load (stall_ex=0): pipeline outputs capture the ex_* inputs and mem_valid<=1.
- REQ-022: During a load, hilo_temp_out<=0 and cnt_out<=0.
- REQ-023: stall_ex=0 with stall_mem=1 is illegal; it shall be treated as hold.
- REQ-024: Latency is exactly one cycle from EX inputs to mem_* outputs; there is no combinational path from inputs to outputs.
- REQ-025: cnt_out holds its captured value unchanged; the block never increments or wraps it.
- REQ-026: An asserted flush during multi-cycle operation clears cnt_out and hilo_temp_out, which aborts the operation.

Reset
- REQ-027: rst_n low clears every output and every internal register to 0 immediately, without waiting for clk.
- REQ-028: Reset mid-stall leaves no retained hold or bubble state.
- REQ-029: The first edge after rst_n deasserts obeys REQ-016.

Configuration
- REQ-030: With EX_MEM_PERF_EN defined, add bubble_cnt (output, 32) and hold_cnt (output, 32).
- REQ-031: With EX_MEM_PERF_EN defined, each counter increments once per bubble or hold edge respectively, wraps from 0xFFFFFFFF to 0, and is cleared by reset only (not by flush).
- REQ-032: Without EX_MEM_PERF_EN, neither port nor counter exists and all other behaviour is identical.

Structure
- REQ-033: REG_ADDR_WIDTH, REG_DATA_WIDTH and the new HILO_TEMP_WIDTH (64) and CNT_WIDTH (2) live in the shared defines file.
- REQ-034: The state encoding of the stall mode (LOAD/BUBBLE/HOLD/FLUSH) lives in the shared defines file.
- REQ-035: One sub-module, ex_mem_perf (the two counters), is instantiated only under EX_MEM_PERF_EN; the rest is flat.

Verification
- REQ-036: Load: ex_w_reg_addr=5'd3, data=0x1234_5678, en=1, no stall -> after 1 edge mem_w_reg_addr=3, mem_w_reg_data=0x12345678, mem_valid=1.
- REQ-037: HI/LO: ex_hi=0xAAAA0000, ex_hilo_wen=1, load -> mem_hi=0xAAAA0000, mem_hilo_wen=1; next load with wen=0 -> mem_hilo_wen=0.
- REQ-038: Bubble: stall_ex=1, stall_mem=0, ex_cnt=1, ex_hilo_temp=0x1_0000_0002 -> mem_w_reg_en=0, mem_valid=0, cnt_out=1, hilo_temp_out=0x100000002; next load -> cnt_out=0.
- REQ-039: Hold: load data=0x55, then stall_ex=stall_mem=1 for 3 edges with ex data changing -> mem_w_reg_data stays 0x55 and hold_cnt=3 (PERF_EN).
- REQ-040: Flush with stall: flush=1, stall_ex=stall_mem=1 -> all outputs 0 next edge.
- REQ-041: Async reset: assert rst_n=0 mid-cycle after a load -> outputs are 0 before the next clk edge; bubble_cnt=0.
